addr_decode_dyn_mp: RTL and testbench

Runtime-programmable, multi-port, registered address decoder. It holds a rule table in flops, written through a config port and lockable until reset. It serves NoPorts independent request channels, each with a 1-cycle valid/ready decode stage. It sits between interconnect request ports and the crossbar select logic, and replaces static, parameter-only decoding where the memory map must change after boot.

---
 rtl/addr_decode_dyn_pkg.sv | 32 +++
 rtl/addr_decode_dyn_match.sv | 55 +++++
 rtl/addr_decode_dyn_mp.sv | 204 ++++++++++++++++++++
 tb/tb_addr_decode_dyn_mp.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_decode_dyn_pkg.sv
// Shared types and helpers for the runtime-programmable address decoder.
// Optional hit counters are enabled by ADDR_DECODE_DYN_HIT_CNT_EN.
package addr_decode_dyn_pkg;

  // Width of an index field able to address n targets (min 1 bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned TplIdxWidth  = 2;
  localparam int unsigned TplAddrWidth = 32;

  // Rule record template. Modules re-declare it with their own widths:
  //   idx        target index
  //   start_addr first address (inclusive)
  //   end_addr   last address (exclusive)
  //   valid      rule takes part in matching
  typedef struct packed {
    logic [TplIdxWidth-1:0]  idx;
    logic [TplAddrWidth-1:0] start_addr;
    logic [TplAddrWidth-1:0] end_addr;
    logic                    valid;
  } rule_t;

  // Why a config write was rejected.
  typedef enum logic [1:0] {
    CFG_OK,
    CFG_LOCKED,
    CFG_BAD_IDX
  } cfg_err_e;

endpackage

// File: rtl/addr_decode_dyn_match.sv
// Combinational priority matcher of one address against the rule table.
// Highest matching slot wins; a rule with start >= end never matches.
module addr_decode_dyn_match
  import addr_decode_dyn_pkg::*;
#(
  parameter int unsigned NoRules      = 8,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned IdxWidth     = idx_width(4),
  parameter int unsigned RuleSelWidth = idx_width(NoRules)
) (
  input  logic [AddrWidth-1:0]                addr_i,
  input  logic [NoRules-1:0][IdxWidth-1:0]    rule_idx_i,
  input  logic [NoRules-1:0][AddrWidth-1:0]   rule_start_i,
  input  logic [NoRules-1:0][AddrWidth-1:0]   rule_end_i,
  input  logic [NoRules-1:0]                  rule_valid_i,
  input  logic                                en_default_idx_i,
  input  logic [IdxWidth-1:0]                 default_idx_i,
  output logic [IdxWidth-1:0]                 idx_o,
  output logic                                err_o,
  output logic [NoRules-1:0]                  hit_o
);

  logic                    any;
  logic [RuleSelWidth-1:0] sel;

  // Scan upward so the last (highest) matching slot is kept.
  always_comb begin
    any = 1'b0;
    sel = '0;
    for (int i = 0; i < NoRules; i++) begin
      if (rule_valid_i[i] &&
          addr_i >= rule_start_i[i] &&
          addr_i <  rule_end_i[i]) begin
        any = 1'b1;
        sel = RuleSelWidth'(i);
      end
    end
  end

  // Resolve index, error and one-hot winner from the scan.
  always_comb begin
    hit_o = '0;
    idx_o = '0;
    err_o = 1'b0;
    if (any) begin
      hit_o = NoRules'(1) << sel;
      idx_o = rule_idx_i[sel];
    end else if (en_default_idx_i) begin
      idx_o = default_idx_i;
    end else begin
      err_o = 1'b1;
    end
  end

endmodule

// File: rtl/addr_decode_dyn_mp.sv
// Multi-port registered address decoder with a lockable runtime rule table.
// Define ADDR_DECODE_DYN_HIT_CNT_EN to add per-rule hit counters.
module addr_decode_dyn_mp
  import addr_decode_dyn_pkg::*;
#(
  parameter int unsigned NoIndices    = 4,
  parameter int unsigned NoRules      = 8,
  parameter int unsigned NoPorts      = 2,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned IdxWidth     = idx_width(NoIndices),
  parameter int unsigned RuleSelWidth = idx_width(NoRules),
  parameter logic [NoRules-1:0] ResetValid = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cfg_we_i,
  input  logic [RuleSelWidth-1:0]       cfg_sel_i,
  input  logic [IdxWidth-1:0]           cfg_idx_i,
  input  logic [AddrWidth-1:0]          cfg_start_i,
  input  logic [AddrWidth-1:0]          cfg_end_i,
  input  logic                          cfg_valid_i,
  input  logic                          cfg_lock_i,
  output logic                          cfg_locked_o,
  output logic                          cfg_err_o,
  input  logic                          en_default_idx_i,
  input  logic [IdxWidth-1:0]           default_idx_i,
  input  logic [NoPorts-1:0]            req_valid_i,
  output logic [NoPorts-1:0]            req_ready_o,
  input  logic [NoPorts*AddrWidth-1:0]  req_addr_i,
  output logic [NoPorts-1:0]            rsp_valid_o,
  input  logic [NoPorts-1:0]            rsp_ready_i,
  output logic [NoPorts*IdxWidth-1:0]   rsp_idx_o,
  output logic [NoPorts-1:0]            rsp_err_o
`ifdef ADDR_DECODE_DYN_HIT_CNT_EN
  ,
  output logic [NoRules*16-1:0]         hit_cnt_o
`endif
);

  typedef struct packed {
    logic [IdxWidth-1:0]  idx;
    logic [AddrWidth-1:0] start_addr;
    logic [AddrWidth-1:0] end_addr;
    logic                 valid;
  } tbl_rule_t;

  localparam logic [IdxWidth:0] IdxLimit = (IdxWidth+1)'(NoIndices);

  tbl_rule_t [NoRules-1:0]              tbl;
  logic [NoRules-1:0][IdxWidth-1:0]     t_idx;
  logic [NoRules-1:0][AddrWidth-1:0]    t_start;
  logic [NoRules-1:0][AddrWidth-1:0]    t_end;
  logic [NoRules-1:0]                   t_valid;

  cfg_err_e                             cause;
  logic                                 wr_ok;
  logic                                 locked;
  logic                                 cfg_err_q;

  logic [NoPorts-1:0]                   acc;
  logic [NoPorts-1:0][IdxWidth-1:0]     m_idx;
  logic [NoPorts-1:0]                   m_err;
  logic [NoPorts-1:0][NoRules-1:0]      m_hit;
  logic [NoPorts-1:0][IdxWidth-1:0]     rsp_idx_q;
  logic [NoPorts-1:0]                   rsp_valid_q;
  logic [NoPorts-1:0]                   rsp_err_q;

  // Classify the config write; lock is checked before the index range.
  always_comb begin
    cause = CFG_OK;
    if (cfg_we_i) begin
      if (locked) begin
        cause = CFG_LOCKED;
      end else if ({1'b0, cfg_idx_i} >= IdxLimit) begin
        cause = CFG_BAD_IDX;
      end
    end
  end

  assign wr_ok = cfg_we_i && (cause == CFG_OK);

  // Rule table storage, written one slot at a time.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NoRules; i++) begin
      if (!rst_ni) begin
        tbl[i] <= '{idx: '0, start_addr: '0,
                    end_addr: '0, valid: ResetValid[i]};
      end else if (wr_ok && cfg_sel_i == RuleSelWidth'(i)) begin
        tbl[i] <= '{idx: cfg_idx_i, start_addr: cfg_start_i,
                    end_addr: cfg_end_i, valid: cfg_valid_i};
      end
    end
  end

  // Sticky lock and one-cycle reject pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      locked    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      locked    <= locked | cfg_lock_i;
      cfg_err_q <= (cause != CFG_OK);
    end
  end

  assign cfg_locked_o = locked;
  assign cfg_err_o    = cfg_err_q;

  // Split the table into per-field buses for the matchers.
  always_comb begin
    for (int i = 0; i < NoRules; i++) begin
      t_idx[i]   = tbl[i].idx;
      t_start[i] = tbl[i].start_addr;
      t_end[i]   = tbl[i].end_addr;
      t_valid[i] = tbl[i].valid;
    end
  end

  for (genvar p = 0; p < NoPorts; p++) begin : g_port
    addr_decode_dyn_match #(
      .NoRules      (NoRules),
      .AddrWidth    (AddrWidth),
      .IdxWidth     (IdxWidth),
      .RuleSelWidth (RuleSelWidth)
    ) u_match (
      .addr_i           (req_addr_i[p*AddrWidth +: AddrWidth]),
      .rule_idx_i       (t_idx),
      .rule_start_i     (t_start),
      .rule_end_i       (t_end),
      .rule_valid_i     (t_valid),
      .en_default_idx_i (en_default_idx_i),
      .default_idx_i    (default_idx_i),
      .idx_o            (m_idx[p]),
      .err_o            (m_err[p]),
      .hit_o            (m_hit[p])
    );
  end

  assign req_ready_o = ~rsp_valid_q | rsp_ready_i;
  assign acc         = req_valid_i & req_ready_o;

  // Per-port result register; holds while downstream stalls.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NoPorts; p++) begin
      if (!rst_ni) begin
        rsp_valid_q[p] <= 1'b0;
        rsp_idx_q[p]   <= '0;
        rsp_err_q[p]   <= 1'b0;
      end else if (acc[p]) begin
        rsp_valid_q[p] <= 1'b1;
        rsp_idx_q[p]   <= m_idx[p];
        rsp_err_q[p]   <= m_err[p];
      end else if (rsp_ready_i[p]) begin
        rsp_valid_q[p] <= 1'b0;
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_idx_o   = rsp_idx_q;
  assign rsp_err_o   = rsp_err_q;

`ifdef ADDR_DECODE_DYN_HIT_CNT_EN
  logic [NoRules-1:0][15:0] hit_cnt;
  logic [NoRules-1:0][15:0] hit_cnt_nxt;
  int unsigned              k;
  logic [16:0]              sum;

  // Add the number of ports this rule won, saturating at 0xFFFF.
  always_comb begin
    k   = 0;
    sum = '0;
    for (int r = 0; r < NoRules; r++) begin
      k = 0;
      for (int p = 0; p < NoPorts; p++) begin
        if (acc[p] && m_hit[p][r]) begin
          k = k + 1;
        end
      end
      sum = {1'b0, hit_cnt[r]} + 17'(k);
      hit_cnt_nxt[r] = sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

  // Counter state; rewriting a slot restarts its count.
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < NoRules; r++) begin
      if (!rst_ni) begin
        hit_cnt[r] <= '0;
      end else if (wr_ok && cfg_sel_i == RuleSelWidth'(r)) begin
        hit_cnt[r] <= '0;
      end else begin
        hit_cnt[r] <= hit_cnt_nxt[r];
      end
    end
  end

  assign hit_cnt_o = hit_cnt;
`else
  logic unused_hit;
  assign unused_hit = ^m_hit;
`endif

endmodule

// File: tb/tb_addr_decode_dyn_mp.sv
// Directed bench for addr_decode_dyn_mp: vector table plus corner sequences.
// Built with NoIndices=5 so an out-of-range index is representable.
module tb_addr_decode_dyn_mp;

  localparam int NI  = 5;
  localparam int NR  = 8;
  localparam int NP  = 2;
  localparam int AW  = 32;
  localparam int IW  = 3;
  localparam int RSW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_we;
  logic [RSW-1:0]  cfg_sel;
  logic [IW-1:0]   cfg_idx;
  logic [AW-1:0]   cfg_start;
  logic [AW-1:0]   cfg_end;
  logic            cfg_valid;
  logic            cfg_lock;
  logic            cfg_locked;
  logic            cfg_err;
  logic            en_def;
  logic [IW-1:0]   def_idx;
  logic [NP-1:0]   req_valid;
  logic [NP-1:0]   req_ready;
  logic [NP*AW-1:0] req_addr;
  logic [NP-1:0]   rsp_valid;
  logic [NP-1:0]   rsp_ready;
  logic [NP*IW-1:0] rsp_idx;
  logic [NP-1:0]   rsp_err;
`ifdef ADDR_DECODE_DYN_HIT_CNT_EN
  logic [NR*16-1:0] hit_cnt;
`endif

  always #5 clk = ~clk;

  addr_decode_dyn_mp #(
    .NoIndices (NI),
    .NoRules   (NR),
    .NoPorts   (NP),
    .AddrWidth (AW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .cfg_we_i         (cfg_we),
    .cfg_sel_i        (cfg_sel),
    .cfg_idx_i        (cfg_idx),
    .cfg_start_i      (cfg_start),
    .cfg_end_i        (cfg_end),
    .cfg_valid_i      (cfg_valid),
    .cfg_lock_i       (cfg_lock),
    .cfg_locked_o     (cfg_locked),
    .cfg_err_o        (cfg_err),
    .en_default_idx_i (en_def),
    .default_idx_i    (def_idx),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_addr_i       (req_addr),
    .rsp_valid_o      (rsp_valid),
    .rsp_ready_i      (rsp_ready),
    .rsp_idx_o        (rsp_idx),
    .rsp_err_o        (rsp_err)
`ifdef ADDR_DECODE_DYN_HIT_CNT_EN
    ,
    .hit_cnt_o        (hit_cnt)
`endif
  );

  typedef struct {
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic          en;
    logic [IW-1:0] def;
    logic [IW-1:0] i0;
    logic [IW-1:0] i1;
    logic          e0;
    logic          e1;
  } vec_t;

  vec_t vecs [8];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string n, input int p, input logic [IW-1:0] idx,
                         input logic err);
    chk({n, "_valid"}, 32'(rsp_valid[p]), 32'd1);
    chk({n, "_idx"}, 32'(rsp_idx[p*IW +: IW]), 32'(idx));
    chk({n, "_err"}, 32'(rsp_err[p]), 32'(err));
  endtask

  task automatic cfg_write(input logic [RSW-1:0] sel, input logic [IW-1:0] idx,
                           input logic [AW-1:0] s, input logic [AW-1:0] e,
                           input logic lock);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_idx   = idx;
    cfg_start = s;
    cfg_end   = e;
    cfg_valid = 1'b1;
    cfg_lock  = lock;
    tick();
    cfg_we    = 1'b0;
    cfg_lock  = 1'b0;
  endtask

  task automatic req(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [NP-1:0] v);
    req_addr  = {a1, a0};
    req_valid = v;
    tick();
    req_valid = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_sel   = '0;
    cfg_idx   = '0;
    cfg_start = '0;
    cfg_end   = '0;
    cfg_valid = 1'b0;
    cfg_lock  = 1'b0;
    en_def    = 1'b0;
    def_idx   = '0;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = '1;

    vecs[0] = '{32'h1850, 32'h1850, 1'b0, 3'd0, 3'd3, 3'd3, 1'b0, 1'b0};
    vecs[1] = '{32'h1900, 32'h1900, 1'b0, 3'd0, 3'd1, 3'd1, 1'b0, 1'b0};
    vecs[2] = '{32'h2000, 32'h2FFF, 1'b0, 3'd0, 3'd2, 3'd2, 1'b0, 1'b0};
    vecs[3] = '{32'h3000, 32'h3000, 1'b1, 3'd3, 3'd3, 3'd3, 1'b0, 1'b0};
    vecs[4] = '{32'h3000, 32'h0000, 1'b0, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0};
    vecs[5] = '{32'h17FF, 32'h1800, 1'b0, 3'd0, 3'd1, 3'd3, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 32'h18FF, 1'b1, 3'd2, 3'd2, 3'd3, 1'b0, 1'b0};
    vecs[7] = '{32'h0FFF, 32'h1000, 1'b0, 3'd0, 3'd2, 3'd1, 1'b0, 1'b0};

    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_idx", 32'(rsp_idx), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_locked", 32'(cfg_locked), 32'h0);
    chk("rst_cfg_err", 32'(cfg_err), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h3);

    // Empty table, no default: error with index 0.
    req(32'h100, 32'h0, 2'b01);
    chk_rsp("t1", 0, 3'd0, 1'b1);
    chk("t1_p1_idle", 32'(rsp_valid[1]), 32'h0);

    cfg_write(3'd2, 3'd1, 32'h1000, 32'h2000, 1'b0);
    chk("t2_cfg_err", 32'(cfg_err), 32'h0);
    req(32'h1FFF, 32'h2000, 2'b11);
    chk_rsp("t2_last_in", 0, 3'd1, 1'b0);
    chk_rsp("t2_end_excl", 1, 3'd0, 1'b1);

    cfg_write(3'd1, 3'd2, 32'h0, 32'h3000, 1'b0);
    cfg_write(3'd5, 3'd3, 32'h1800, 32'h1900, 1'b0);

    // Back-to-back vectors on both ports.
    for (int i = 0; i < 8; i++) begin
      en_def    = vecs[i].en;
      def_idx   = vecs[i].def;
      req_addr  = {vecs[i].a1, vecs[i].a0};
      req_valid = 2'b11;
      tick();
      chk_rsp($sformatf("vec%0d_p0", i), 0, vecs[i].i0, vecs[i].e0);
      chk_rsp($sformatf("vec%0d_p1", i), 1, vecs[i].i1, vecs[i].e1);
    end
    req_valid = '0;
    en_def    = 1'b0;
    def_idx   = '0;
    tick();
    chk("drain_valid", 32'(rsp_valid), 32'h0);

    // Backpressure on port 0.
    req_addr  = {32'h0, 32'h1850};
    req_valid = 2'b01;
    tick();
    chk_rsp("bp_first", 0, 3'd3, 1'b0);
    rsp_ready = 2'b10;
    req_addr  = {32'h0, 32'h0};
    #1;
    chk("bp_ready_low", 32'(req_ready[0]), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_rsp($sformatf("bp_hold%0d", i), 0, 3'd3, 1'b0);
      chk($sformatf("bp_ready%0d", i), 32'(req_ready[0]), 32'h0);
    end
    rsp_ready = 2'b11;
    #1;
    chk("bp_ready_rel", 32'(req_ready[0]), 32'h1);
    tick();
    chk_rsp("bp_next", 0, 3'd2, 1'b0);
    req_addr = {32'h0, 32'h1000};
    tick();
    chk_rsp("bp_next2", 0, 3'd1, 1'b0);
    req_valid = '0;
    tick();
    chk("bp_drop", 32'(rsp_valid[0]), 32'h0);

    // Index range boundary and lock.
    cfg_write(3'd0, 3'd5, 32'h4000, 32'h5000, 1'b0);
    chk("badidx_pulse", 32'(cfg_err), 32'h1);
    tick();
    chk("badidx_clear", 32'(cfg_err), 32'h0);
    req(32'h4000, 32'h0, 2'b01);
    chk_rsp("badidx_nochg", 0, 3'd0, 1'b1);
    cfg_write(3'd6, 3'd4, 32'h4000, 32'h5000, 1'b0);
    chk("maxidx_ok", 32'(cfg_err), 32'h0);
    req(32'h4000, 32'h0, 2'b01);
    chk_rsp("maxidx_dec", 0, 3'd4, 1'b0);
    cfg_write(3'd7, 3'd3, 32'h5000, 32'h6000, 1'b1);
    chk("lockwr_ok", 32'(cfg_err), 32'h0);
    chk("lock_set", 32'(cfg_locked), 32'h1);
    req(32'h5000, 32'h0, 2'b01);
    chk_rsp("lockwr_dec", 0, 3'd3, 1'b0);
    cfg_write(3'd0, 3'd1, 32'h6000, 32'h7000, 1'b0);
    chk("locked_pulse", 32'(cfg_err), 32'h1);
    tick();
    chk("locked_clear", 32'(cfg_err), 32'h0);
    chk("lock_sticky", 32'(cfg_locked), 32'h1);
    req(32'h6000, 32'h0, 2'b01);
    chk_rsp("locked_nochg", 0, 3'd0, 1'b1);

    // Reset mid-stream clears results, lock and table.
    req_addr  = {32'h1850, 32'h1850};
    req_valid = 2'b11;
    tick();
    chk("pre_rst_valid", 32'(rsp_valid), 32'h3);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_locked", 32'(cfg_locked), 32'h0);
    rst_n     = 1'b1;
    req_valid = '0;
    req(32'h1850, 32'h1FFF, 2'b11);
    chk_rsp("post_rst_p0", 0, 3'd0, 1'b1);
    chk_rsp("post_rst_p1", 1, 3'd0, 1'b1);

    // Write and request in the same cycle: old table applies.
    cfg_we    = 1'b1;
    cfg_sel   = 3'd3;
    cfg_idx   = 3'd2;
    cfg_start = 32'h100;
    cfg_end   = 32'h200;
    cfg_valid = 1'b1;
    req(32'h180, 32'h0, 2'b01);
    cfg_we = 1'b0;
    chk_rsp("samecyc_old", 0, 3'd0, 1'b1);
    chk("samecyc_cfg_err", 32'(cfg_err), 32'h0);
    req(32'h180, 32'h0, 2'b01);
    chk_rsp("samecyc_new", 0, 3'd2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
